stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Run/pause/clear sequencer for the stopwatch digit-counter chain (hundredths, tenths, seconds-units, seconds-tens).
- Divides the board clock into a timebase tick.
- Generates the per-digit count enables with carry cascading, using "digit at max" status fed back from the chain.
- Issues a synchronous clear to every digit.
- The digit counters hold no control logic; this block is their only sequencer.

Parameters:
TICK_DIV, 500000, clock cycles per timebase tick (50 MHz / 500000 = 100 Hz); legal range ≥ 2.
DIV_W, 19, width of the divider counter; must satisfy 2^DIV_W ≥ TICK_DIV.
NUM_DIG, 4, number of cascaded digit counters controlled.

Ports:
Clock  in  1  system clock; all state on rising edge.
Resetn  in  1  asynchronous, active-low reset.
start_stop  in  1  one-cycle pulse (debounced upstream); toggles run/pause.
clear_req  in  1  one-cycle pulse; zero the chain and stop.
lap  in  1  one-cycle pulse; lap display hold (LAP_EN only).
at_max  in  NUM_DIG  at_max[i]=1 when digit i sits at its terminal value (9, or 5 for the tens of seconds).
tick  out  1  registered one-cycle timebase pulse; asserts only in RUN.
dig_en  out  NUM_DIG  per-digit count enable (the E input of each digit counter).
dig_clr  out  1  synchronous clear to all digits.
running  out  1  high in RUN.
wrap  out  1  one-cycle pulse when the whole chain rolls over to all-zero.
lap_hold  out  1  display freeze (0 when LAP_EN is undefined).

Behaviour:
- States: IDLE (chain zero, stopped), RUN, PAUSE, CLEAR.
- Reset (Resetn=0, async): state=IDLE, divider=0, tick=0, lap_hold=0, all outputs 0.
- IDLE: start_stop → RUN. clear_req → CLEAR.
- RUN: start_stop → PAUSE. clear_req → CLEAR.
- PAUSE: start_stop → RUN. clear_req → CLEAR.
- CLEAR: lasts exactly one cycle with dig_clr=1, divider cleared, lap_hold cleared; then → IDLE unconditionally. Pulses arriving during CLEAR are ignored.
- Priority: clear_req beats start_stop in the same cycle, in every state.
- Divider:
  - Counts 0..TICK_DIV-1 only in RUN.
  - At TICK_DIV-1 it returns to 0 and tick is registered high for the following cycle.
  - In PAUSE it holds its value, so the fractional tick is preserved across pause/resume.
  - Cleared in CLEAR and IDLE.
- Entering PAUSE on the same edge a tick is registered drops that tick: tick is gated by state==RUN.
- Enables (combinational from registered tick, state and at_max):
  - dig_en[0] = tick & running.
  - dig_en[i] = tick & running & AND(at_max[i-1:0]).
- wrap = tick & running & AND(at_max[NUM_DIG-1:0]). The chain self-wraps to 0 and the block stays in RUN.
- Latency: start_stop pulse at cycle t → running=1 at t+1 → first tick at t+TICK_DIV+1 (from IDLE).
- dig_clr and dig_en are never high in the same cycle.

Optional Feature:
Macro LAP_EN.
- Defined:
  - lap pulse in RUN toggles lap_hold; the display muxes frozen digits while counting continues.
  - lap in PAUSE or IDLE is ignored.
  - lap_hold is cleared by CLEAR and reset.
  - lap together with start_stop in the same cycle: both take effect.
- Undefined: lap is ignored and lap_hold is tied 0.

Decomposition:
- Package stopwatch_pkg holds:
  - State encoding constants (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, CLEAR=2'd3).
  - NUM_DIG default.
  - Digit terminal values (9, 9, 9, 5).
- One sub-module, tick_divider: parameterized by TICK_DIV/DIV_W, with inputs run and clr and output tick.
- The FSM and enable cascade stay in stopwatch_ctrl.

Test Plan:
All scenarios use TICK_DIV=4 and a behavioral 4-digit chain model.
- Reset and start: Resetn low mid-RUN → all outputs 0 immediately. Release, then start_stop → running=1 next cycle; first tick 5 cycles after the pulse; then one tick every 4 cycles.
- Carry cascade: run until digits read 0,9,9,9 (MSD..LSD) → on that tick dig_en=4'b1111 for 1 cycle; chain reads 1,0,0,0.
- Full wrap: preload at_max=4'b1111 while running → wrap=1 and dig_en=4'b1111 for exactly 1 cycle; state stays RUN.
- Pause preserves phase: pause with divider=2, hold 20 cycles, resume → next tick after 2 cycles; no tick during PAUSE.
- Clear priority: clear_req and start_stop same cycle in RUN → CLEAR (dig_clr=1 for 1 cycle) → IDLE, running=0; pulses during CLEAR ignored.
- LAP_EN: lap in RUN → lap_hold=1 while dig_en keeps pulsing; second lap → 0; lap in PAUSE → no change. Without the macro, lap_hold stays 0.

Source files
------------

// File: rtl/stopwatch_ctrl_pkg.sv
// Purpose : shared types and constants for the stopwatch sequencer and its digit chain.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package stopwatch_pkg;

  // Sequencer states; encodings are fixed so they read the same in every dump.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    CLEAR = 2'd3
  } sw_state_e;

  // Hundredths, tenths, seconds-units, seconds-tens.
  localparam int NUM_DIG_DEF = 4;

  // Terminal value of each digit, index 0 = least significant digit.
  localparam int DIG_TERM [NUM_DIG_DEF] = '{9, 9, 9, 5};

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Purpose : control/status bundle between the stopwatch sequencer and the digit chain.
// Latency : n/a (wires only).
// Backpr. : none; all signals are single-cycle pulses or levels.
// Ports   : master = input side (buttons + chain status), slave = the sequencer.
interface stopwatch_ctrl_if
  import stopwatch_pkg::*;
#(
  parameter int NUM_DIG = NUM_DIG_DEF
);

  logic               start_stop;
  logic               clear_req;
  logic               lap;
  logic [NUM_DIG-1:0] at_max;
  logic               tick;
  logic [NUM_DIG-1:0] dig_en;
  logic               dig_clr;
  logic               running;
  logic               wrap;
  logic               lap_hold;

  modport master (
    output start_stop, clear_req, lap, at_max,
    input  tick, dig_en, dig_clr, running, wrap, lap_hold
  );

  modport slave (
    input  start_stop, clear_req, lap, at_max,
    output tick, dig_en, dig_clr, running, wrap, lap_hold
  );

endinterface

// File: rtl/stopwatch_ctrl_tick_divider.sv
// Purpose : divides Clock down to a one-cycle timebase pulse every TICK_DIV cycles of run.
// Latency : tick is registered; it is high the cycle after the count reaches TICK_DIV-1.
// Backpr. : run=0 freezes the count (phase kept); clr zeroes it and drops any pending tick.
// Ports   : Clock, Resetn (async, active-low), run, clr, tick.
module tick_divider #(
  parameter int TICK_DIV = 500000,
  parameter int DIV_W    = 19
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (run) begin
      if (cnt == LAST) begin
        cnt  <= '0;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt + DIV_W'(1);
        tick <= 1'b0;
      end
    end else begin
      // Paused: hold the partial count so resume keeps the sub-tick phase.
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Purpose : run/pause/clear sequencer for the stopwatch digit chain; timebase, carry enables, clear.
// Latency : start_stop -> running next cycle -> first tick TICK_DIV+1 cycles after the pulse.
// Backpr. : none; pulses are accepted every cycle except during the single CLEAR cycle.
// Ports   : Clock, Resetn (async, active-low), sw (stopwatch_ctrl_if.slave).
// Options : define LAP_EN to enable the lap display hold; otherwise lap is ignored, lap_hold=0.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 500000,
  parameter int DIV_W    = 19,
  parameter int NUM_DIG  = NUM_DIG_DEF
) (
  input  logic            Clock,
  input  logic            Resetn,
  stopwatch_ctrl_if.slave sw
);

  sw_state_e state;
  logic      running_q;
  logic      clr_q;
  logic      lap_q;

  logic      div_run;
  logic      div_clr;
  logic      div_tick;
  logic      tick_out;

  logic [NUM_DIG-1:0] en;
  logic               carry;

  assign div_run = (state == RUN);
  assign div_clr = (state == IDLE) || (state == CLEAR);

  tick_divider #(
    .TICK_DIV (TICK_DIV),
    .DIV_W    (DIV_W)
  ) u_div (
    .Clock  (Clock),
    .Resetn (Resetn),
    .run    (div_run),
    .clr    (div_clr),
    .tick   (div_tick)
  );

  // clear_req is tested first in every state so it wins over start_stop.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state     <= IDLE;
      running_q <= 1'b0;
      clr_q     <= 1'b0;
      lap_q     <= 1'b0;
    end else begin
      clr_q <= 1'b0;
      unique case (state)
        IDLE, PAUSE: begin
          if (sw.clear_req) begin
            state <= CLEAR;
            clr_q <= 1'b1;
            lap_q <= 1'b0;
          end else if (sw.start_stop) begin
            state     <= RUN;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          if (sw.clear_req) begin
            state     <= CLEAR;
            running_q <= 1'b0;
            clr_q     <= 1'b1;
            lap_q     <= 1'b0;
          end else begin
            if (sw.start_stop) begin
              state     <= PAUSE;
              running_q <= 1'b0;
            end
`ifdef LAP_EN
            if (sw.lap) begin
              lap_q <= ~lap_q;
            end
`endif
          end
        end
        CLEAR: begin
          // Single-cycle state; any pulse seen here is dropped.
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  // A tick registered on the same edge that leaves RUN must not reach the chain.
  assign tick_out = div_tick & running_q;

  // Ripple carry: digit i counts when the tick is present and every lower digit is at max.
  always_comb begin
    en    = '0;
    carry = tick_out;
    for (int i = 0; i < NUM_DIG; i++) begin
      en[i] = carry;
      carry = carry & sw.at_max[i];
    end
  end

  assign sw.tick    = tick_out;
  assign sw.dig_en  = en;
  assign sw.wrap    = carry;
  assign sw.dig_clr = clr_q;
  assign sw.running = running_q;

`ifdef LAP_EN
  assign sw.lap_hold = lap_q;
`else
  assign sw.lap_hold = 1'b0;
  logic unused_lap;
  assign unused_lap = sw.lap ^ lap_q;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Purpose : directed self-checking bench for stopwatch_ctrl with a 4-digit chain model.
// Latency : TICK_DIV=4, so ticks land 5 cycles after a start from IDLE, then every 4.
// Backpr. : n/a.
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  logic Clock = 1'b0;
  logic Resetn;

  int errors = 0;
  int checks = 0;

  always #5 Clock = ~Clock;

  stopwatch_ctrl_if #(.NUM_DIG(4)) sw ();

  stopwatch_ctrl #(
    .TICK_DIV (4),
    .DIV_W    (3),
    .NUM_DIG  (4)
  ) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .sw     (sw)
  );

  // Behavioural digit chain: plain counters driven only by dig_en/dig_clr.
  logic [3:0] dig    [4];
  logic [3:0] ld_val [4];
  logic       ld;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < 4; i++) dig[i] <= 4'd0;
    end else if (ld) begin
      for (int i = 0; i < 4; i++) dig[i] <= ld_val[i];
    end else if (sw.dig_clr) begin
      for (int i = 0; i < 4; i++) dig[i] <= 4'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sw.dig_en[i]) dig[i] <= (dig[i] == 4'(DIG_TERM[i])) ? 4'd0 : dig[i] + 4'd1;
      end
    end
  end

  always_comb begin
    sw.at_max = '0;
    for (int i = 0; i < 4; i++) sw.at_max[i] = (dig[i] == 4'(DIG_TERM[i]));
  end

  function automatic logic [15:0] chain();
    return {dig[3], dig[2], dig[1], dig[0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic pulse_start();
    sw.start_stop = 1'b1;
    step();
    sw.start_stop = 1'b0;
  endtask

  // Steps until tick is seen or the budget runs out; n is the number of steps taken.
  task automatic wait_tick(input int limit, output int n);
    n = 0;
    while (sw.tick !== 1'b1 && n < limit) begin
      step();
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  n;
    logic e;

    Resetn        = 1'b0;
    sw.start_stop = 1'b0;
    sw.clear_req  = 1'b0;
    sw.lap        = 1'b0;
    ld            = 1'b0;
    ld_val        = '{4'd0, 4'd0, 4'd0, 4'd0};

    // Reset state
    repeat (3) step();
    chk("rst_running",  sw.running,  0);
    chk("rst_tick",     sw.tick,     0);
    chk("rst_dig_en",   sw.dig_en,   0);
    chk("rst_dig_clr",  sw.dig_clr,  0);
    chk("rst_wrap",     sw.wrap,     0);
    chk("rst_lap_hold", sw.lap_hold, 0);
    Resetn = 1'b1;
    step();

    // Start, then async reset in the middle of RUN
    pulse_start();
    chk("start_running", sw.running, 1);
    repeat (6) step();
    #2 Resetn = 1'b0;
    #1;
    chk("arst_running", sw.running, 0);
    chk("arst_tick",    sw.tick,    0);
    chk("arst_dig_en",  sw.dig_en,  0);
    step();
    Resetn = 1'b1;
    step();

    // Start latency and tick period: pulse at t, ticks at t+5, t+9, t+13
    pulse_start();
    chk("lat_running", sw.running, 1);
    for (int c = 1; c <= 13; c++) begin
      e = (c >= 5) && (((c - 1) % 4) == 0);
      chk("lat_tick", sw.tick, e);
      if (c < 13) step();
    end
    chk("lat_dig_en", sw.dig_en, 4'b0001);
    chk("lat_chain",  chain(),   16'h0002);

    // Carry cascade 0,9,9,9 -> 1,0,0,0
    pulse_start();
    chk("pause_running", sw.running, 0);
    ld_val = '{4'd9, 4'd9, 4'd9, 4'd0};
    ld     = 1'b1;
    step();
    ld     = 1'b0;
    chk("casc_load", chain(), 16'h0999);
    pulse_start();
    wait_tick(8, n);
    chk("casc_lat",    n,          3);
    chk("casc_en",     sw.dig_en,  4'b1111);
    chk("casc_wrap",   sw.wrap,    0);
    step();
    chk("casc_en_off", sw.dig_en,  0);
    chk("casc_chain",  chain(),    16'h1000);

    // Pause with divider at 2, hold 20 cycles, then full wrap from 5,9,9,9
    pulse_start();
    ld_val = '{4'd9, 4'd9, 4'd9, 4'd5};
    ld     = 1'b1;
    for (int k = 0; k < 20; k++) begin
      chk("pause_tick", sw.tick, 0);
      step();
      ld = 1'b0;
    end
    chk("wrap_load", chain(), 16'h5999);
    pulse_start();
    wait_tick(8, n);
    chk("phase_lat",    n,          2);
    chk("wrap_pulse",   sw.wrap,    1);
    chk("wrap_en",      sw.dig_en,  4'b1111);
    chk("wrap_running", sw.running, 1);
    step();
    chk("wrap_off",     sw.wrap,    0);
    chk("wrap_en_off",  sw.dig_en,  0);
    chk("wrap_stay",    sw.running, 1);
    chk("wrap_chain",   chain(),    16'h0000);

    // Clear beats start_stop; pulses during CLEAR are ignored
    wait_tick(8, n);
    chk("pre_clr_lat", n, 3);
    step();
    chk("pre_clr_chain", chain(), 16'h0001);
    sw.clear_req  = 1'b1;
    sw.start_stop = 1'b1;
    step();
    sw.clear_req  = 1'b0;
    chk("clr_dig_clr", sw.dig_clr, 1);
    chk("clr_running", sw.running, 0);
    chk("clr_dig_en",  sw.dig_en,  0);
    step();
    sw.start_stop = 1'b0;
    chk("idle_dig_clr", sw.dig_clr, 0);
    chk("idle_running", sw.running, 0);
    chk("idle_chain",   chain(),    16'h0000);
    step();
    chk("idle_ignored", sw.running, 0);

    // Restart from IDLE: divider was cleared, so full latency again
    pulse_start();
    chk("restart_running", sw.running, 1);
    wait_tick(8, n);
    chk("restart_lat", n, 4);

`ifdef LAP_EN
    sw.lap = 1'b1;
    step();
    sw.lap = 1'b0;
    chk("lap_on", sw.lap_hold, 1);
    wait_tick(8, n);
    chk("lap_counting", sw.dig_en[0], 1);
    chk("lap_held",     sw.lap_hold,  1);
    pulse_start();
    sw.lap = 1'b1;
    step();
    sw.lap = 1'b0;
    chk("lap_pause", sw.lap_hold, 1);
    pulse_start();
    sw.lap = 1'b1;
    step();
    sw.lap = 1'b0;
    chk("lap_off", sw.lap_hold, 0);
`else
    sw.lap = 1'b1;
    step();
    sw.lap = 1'b0;
    chk("lap_tied", sw.lap_hold, 0);
    wait_tick(8, n);
    chk("lap_tied_counting", sw.dig_en[0], 1);
    chk("lap_tied_tick",     sw.lap_hold,  0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
